// File: rtl/mux_n_arb.sv
// -----------------------------------------------------------------------------
// mux_n_arb
//
// N-channel valid/ready multiplexer with a one-word registered output.
// Two selection modes:
//   mode = 0 : direct select -- only channel `sel` may be granted.
//   mode = 1 : round-robin   -- the first valid channel after the last
//              granted one (ptr+1, ptr+2, ... modulo N) is granted.
// The output register accepts a new word whenever it is empty or is being
// drained in the same cycle, so a continuously ready sink sees one word per
// cycle with no bubbles.
//
// Parameters
//   N  : number of input channels (2..16)
//   W  : data width per channel
//   SW : select / channel-index width, $clog2(N) (derived)
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   mode      : 0 = direct select, 1 = round-robin
//   sel       : channel index used in direct-select mode
//   in_data   : channel i at bits [i*W +: W]
//   in_valid  : per-channel data valid
//   in_ready  : per-channel accept (one-hot on the granted channel, or zero)
//   out_data  : registered selected data
//   out_valid : out_data / out_ch hold a word
//   out_ch    : index of the channel that supplied out_data
//   out_ready : downstream accept
// -----------------------------------------------------------------------------
module mux_n_arb #(
  parameter  int N  = 4,
  parameter  int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic          load;
  logic          grant_valid;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic [SW-1:0] ptr;
  logic          sel_in_range;
  logic [SW:0]   rr_idx;

  // Output register is free when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // One extra bit so sel == N..2^SW-1 (non-power-of-two N) is detectable.
  assign sel_in_range = ({1'b0, sel} < (SW+1)'(N));

  // Grant decision.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    rr_idx      = '0;
    if (load) begin
      if (!mode) begin
        if (sel_in_range && in_valid[sel]) begin
          grant_valid = 1'b1;
          grant       = sel;
        end
      end else begin
        // Scan farthest-first so the nearest valid channel after ptr is
        // the last (winning) assignment. ptr+k <= 2N-1 needs at most one
        // subtraction of N to wrap, which also covers non-power-of-two N.
        for (int k = N; k >= 1; k--) begin
          rr_idx = {1'b0, ptr} + (SW+1)'(k);
          if (rr_idx >= (SW+1)'(N)) begin
            rr_idx = rr_idx - (SW+1)'(N);
          end
          if (in_valid[rr_idx[SW-1:0]]) begin
            grant_valid = 1'b1;
            grant       = rr_idx[SW-1:0];
          end
        end
      end
    end
  end

  // Accept strobe and data mux for the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        in_ready[i] = grant_valid;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  // Output register and round-robin pointer. A grant implies in_valid on
  // the granted channel, so grant_valid is exactly the transfer condition.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      // Pointer parks on the last channel so channel 0 is searched first.
      ptr       <= SW'(N - 1);
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        ptr       <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_n_arb
//
// Self-checking bench for mux_n_arb with N=4, W=8. Directed scenarios cover
// direct select, round-robin order, back-pressure, wrap-around, the no-grant
// case and a mid-cycle reset; a randomized run is compared against a
// cycle-level reference model built from the selection rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mux_n_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  mux_n_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", out_data); end
    tests_run++;
    if (out_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    in_data   = {8'h11, 8'hA5, 8'h22, 8'h33};
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 4'b0100) begin tests_failed++; $display("FAIL direct_ready: got %b want 0100", in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL direct_valid: got %b want 1", out_valid); end
    tests_run++;
    if (out_data !== 8'hA5) begin tests_failed++; $display("FAIL direct_data: got %h want a5", out_data); end
    tests_run++;
    if (out_ch !== 2'd2) begin tests_failed++; $display("FAIL direct_ch: got %0d want 2", out_ch); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 4'(1 << (i % 4))) begin
        tests_failed++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << (i % 4)));
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== 8'(8'h11 * ((i % 4) + 1))) begin
        tests_failed++;
        $display("FAIL rr_word[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, i % 4, 8'(8'h11 * ((i % 4) + 1)));
      end
    end
  endtask

  // Follows test_round_robin: holding ch0 (8'h11), ptr = 0.
  task automatic test_back_pressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", i, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 4'b0010) begin tests_failed++; $display("FAIL release_ready: got %b want 0010", in_ready); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) begin
      tests_failed++;
      $display("FAIL release_word: got v=%b ch=%0d d=%h want v=1 ch=1 d=22", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode      = 1'b1;
    in_data   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_ch !== 2'd1) begin tests_failed++; $display("FAIL wrap_setup: got ch=%0d want 1", out_ch); end
    in_valid = 4'b0011;
    #1;
    tests_run++;
    if (in_ready !== 4'b0001) begin tests_failed++; $display("FAIL wrap_ready: got %b want 0001", in_ready); end
    tick();
    tests_run++;
    if (out_ch !== 2'd0 || out_data !== 8'hA1) begin
      tests_failed++; $display("FAIL wrap_ch0: got ch=%0d d=%h want ch=0 d=a1", out_ch, out_data);
    end
    tick();
    tests_run++;
    if (out_ch !== 2'd1 || out_data !== 8'hB2) begin
      tests_failed++; $display("FAIL wrap_ch1: got ch=%0d d=%h want ch=1 d=b2", out_ch, out_data);
    end
  endtask

  // Follows test_wrap: holding ch1 (8'hB2).
  task automatic test_no_grant();
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b1101;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 4'b0000) begin tests_failed++; $display("FAIL nogrant_ready: got %b want 0000", in_ready); end
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL nogrant_pre: got v=%b want 1", out_valid); end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_ch !== 2'd1 || out_data !== 8'hB2) begin
      tests_failed++;
      $display("FAIL nogrant_drop: got v=%b ch=%0d d=%h want v=0 ch=1 d=b2", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd3;
    in_data   = {8'h5A, 8'h00, 8'h00, 8'h00};
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h5A) begin
      tests_failed++; $display("FAIL midrst_setup: got v=%b ch=%0d d=%h want v=1 ch=3 d=5a", out_valid, out_ch, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      tests_failed++; $display("FAIL midrst_clear: got v=%b ch=%0d d=%h want v=0 ch=0 d=00", out_valid, out_ch, out_data);
    end
    #1;
    rst       = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
      tests_failed++; $display("FAIL midrst_first: got v=%b ch=%0d d=%h want v=1 ch=0 d=11", out_valid, out_ch, out_data);
    end
  endtask

  // Randomized run against a reference model of the selection rules.
  task automatic test_random();
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;
    bit       load;
    bit       has;
    int       g;
    int       cand;
    bit [3:0] exp_ready;
    do_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = N - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'($urandom);
      #1;
      load = !m_valid || out_ready;
      has  = 1'b0;
      g    = 0;
      if (load) begin
        if (!mode) begin
          if (in_valid[sel]) begin has = 1'b1; g = int'(sel); end
        end else begin
          for (int k = 1; k <= N && !has; k++) begin
            cand = (m_ptr + k) % N;
            if (in_valid[cand]) begin has = 1'b1; g = cand; end
          end
        end
      end
      exp_ready = has ? 4'(1 << g) : 4'b0000;
      tests_run++;
      if (in_ready !== exp_ready) begin
        tests_failed++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready);
      end
      if (load) begin
        if (has) begin
          m_valid = 1'b1;
          m_data  = in_data[g*W +: W];
          m_ch    = g;
          m_ptr   = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
      tests_run++;
      if (out_valid !== m_valid || out_ch !== 2'(m_ch) || out_data !== m_data) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: got v=%b ch=%0d d=%h want v=%b ch=%0d d=%h",
                 cyc, out_valid, out_ch, out_data, m_valid, m_ch, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_round_robin();
    test_back_pressure();
    test_wrap();
    test_no_grant();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
